// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/clear/lap sequencer for an SS.cc BCD stopwatch.
// An internal prescaler divides clk down to the centisecond count rate.
// Optional lap feature: define STOPWATCH_LAP_EN to build the LAP state and lap latch.
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        tick,
  output logic        wrap
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
`ifdef STOPWATCH_LAP_EN
    S_LAP,
`endif
    S_PAUSE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   disp_q, disp_d;
  logic          running_q, running_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic [15:0]   inc_cnt;
  logic          inc_wrap;
  logic          active;
  logic          inc;

`ifdef STOPWATCH_LAP_EN
  logic [15:0]   latch_q, latch_d;
  logic          lap_active_q, lap_active_d;
`else
  logic          unused_lap;
  assign unused_lap = lap;
`endif

  // BCD ripple increment of the live count; sec_tens rolling 5->0 is the wrap
  always_comb begin
    inc_cnt  = count_q;
    inc_wrap = 1'b0;
    if (count_q[3:0] < 4'd9) begin
      inc_cnt[3:0] = count_q[3:0] + 4'd1;
    end else begin
      inc_cnt[3:0] = '0;
      if (count_q[7:4] < 4'd9) begin
        inc_cnt[7:4] = count_q[7:4] + 4'd1;
      end else begin
        inc_cnt[7:4] = '0;
        if (count_q[11:8] < 4'd9) begin
          inc_cnt[11:8] = count_q[11:8] + 4'd1;
        end else begin
          inc_cnt[11:8] = '0;
          if (count_q[15:12] < 4'd5) begin
            inc_cnt[15:12] = count_q[15:12] + 4'd1;
          end else begin
            inc_cnt[15:12] = '0;
            inc_wrap       = 1'b1;
          end
        end
      end
    end
  end

  // Next state, prescaler, count and registered-output values
  always_comb begin
    state_d   = state_q;
    psc_d     = psc_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
`ifdef STOPWATCH_LAP_EN
    latch_d   = latch_q;
    active    = (state_q == S_RUN) || (state_q == S_LAP);
`else
    active    = (state_q == S_RUN);
`endif
    inc       = active && (psc_q == PSC_MAX);

    if (active) begin
      psc_d = inc ? '0 : psc_q + 1'b1;
    end
    if (inc) begin
      count_d = inc_cnt;
      tick_d  = 1'b1;
      wrap_d  = inc_wrap;
    end

    // Button handling overrides the count path only where clear demands it;
    // start_stop/lap change the state but let a coincident increment land.
    if (clear) begin
      state_d = S_IDLE;
      psc_d   = '0;
      count_d = '0;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
`ifdef STOPWATCH_LAP_EN
      latch_d = '0;
`endif
    end else if (start_stop) begin
      unique case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
`ifdef STOPWATCH_LAP_EN
        S_LAP:   state_d = S_PAUSE;
`endif
        default: state_d = S_IDLE;
      endcase
`ifdef STOPWATCH_LAP_EN
    end else if (lap) begin
      if (state_q == S_RUN) begin
        state_d = S_LAP;
        latch_d = count_q;
      end else if (state_q == S_LAP) begin
        state_d = S_RUN;
      end
`endif
    end

`ifdef STOPWATCH_LAP_EN
    running_d    = (state_d == S_RUN) || (state_d == S_LAP);
    lap_active_d = (state_d == S_LAP);
    disp_d       = (state_d == S_LAP) ? latch_d : count_d;
`else
    running_d    = (state_d == S_RUN);
    disp_d       = count_d;
`endif
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      psc_q        <= '0;
      count_q      <= '0;
      disp_q       <= '0;
      running_q    <= 1'b0;
      tick_q       <= 1'b0;
      wrap_q       <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      latch_q      <= '0;
      lap_active_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      psc_q        <= psc_d;
      count_q      <= count_d;
      disp_q       <= disp_d;
      running_q    <= running_d;
      tick_q       <= tick_d;
      wrap_q       <= wrap_d;
`ifdef STOPWATCH_LAP_EN
      latch_q      <= latch_d;
      lap_active_q <= lap_active_d;
`endif
    end
  end

  assign disp_bcd = disp_q;
  assign running  = running_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
`ifdef STOPWATCH_LAP_EN
  assign lap_active = lap_active_q;
`else
  assign lap_active = 1'b0;
`endif

endmodule
